// File: rtl/lr_sc_reservation_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lr_sc_reservation_unit_if: MA-stage LR/SC request, write-snoop and       |
// | verdict bundle. Revision: 1.0                                            |
// +--------------------------------------------------------------------------+
interface lr_sc_reservation_unit_if #(
  parameter int XLEN = 32
);
  logic            i_stall;
  logic            i_flush;
  logic            i_is_lr;
  logic            i_is_sc;
  logic [XLEN-1:0] i_data_memory_address;
  logic            i_store_write_enable;
  logic [XLEN-1:0] i_store_address;
  logic            i_amo_write_enable;
  logic [XLEN-1:0] i_amo_write_addr;
  logic            o_sc_write_enable;
  logic            o_sc_success;
  logic [XLEN-1:0] o_sc_rd_value;
  logic            o_reservation_valid;
  logic [XLEN-1:0] o_reservation_addr;

  modport master (
    output i_stall, i_flush, i_is_lr, i_is_sc, i_data_memory_address,
           i_store_write_enable, i_store_address, i_amo_write_enable, i_amo_write_addr,
    input  o_sc_write_enable, o_sc_success, o_sc_rd_value,
           o_reservation_valid, o_reservation_addr
  );

  modport slave (
    input  i_stall, i_flush, i_is_lr, i_is_sc, i_data_memory_address,
           i_store_write_enable, i_store_address, i_amo_write_enable, i_amo_write_addr,
    output o_sc_write_enable, o_sc_success, o_sc_rd_value,
           o_reservation_valid, o_reservation_addr
  );
endinterface
`default_nettype wire

// File: rtl/lr_sc_reservation_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lr_sc_reservation_unit: single-hart LR.W/SC.W reservation tracker and    |
// | SC verdict. Optional reservation lifetime via LR_SC_TIMEOUT_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lr_sc_reservation_unit #(
  parameter int XLEN           = 32,
  parameter int GRANULE_LOG2   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic                 i_clk,
  input  wire logic                 i_rst,
  lr_sc_reservation_unit_if.slave   bus
);

  localparam logic [0:0] RSV_NONE = 1'b0;
  localparam logic [0:0] RSV_HELD = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] rsv_addr_q, rsv_addr_d;
  logic [XLEN-1:0] sc_rd_value_q, sc_rd_value_d;

  logic w_lr_accept;
  logic w_sc_accept;
  logic w_held;
  logic w_sc_match;
  logic w_store_hit;
  logic w_amo_hit;
  logic w_sc_success;
  logic w_timeout_expired;

  function automatic logic granule_eq(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (a >> GRANULE_LOG2) == (b >> GRANULE_LOG2);
  endfunction

  assign w_lr_accept  = bus.i_is_lr & ~bus.i_stall & ~bus.i_flush;
  assign w_sc_accept  = bus.i_is_sc & ~bus.i_stall & ~bus.i_flush;
  assign w_held       = (state_q == RSV_HELD);
  assign w_sc_match   = granule_eq(bus.i_data_memory_address, rsv_addr_q);
  assign w_store_hit  = bus.i_store_write_enable & granule_eq(bus.i_store_address, rsv_addr_q);
  assign w_amo_hit    = bus.i_amo_write_enable & granule_eq(bus.i_amo_write_addr, rsv_addr_q);
  assign w_sc_success = w_sc_accept & w_held & w_sc_match;

`ifdef LR_SC_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TIMER_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (w_lr_accept) begin
      timer_d = TIMER_W'(TIMEOUT_CYCLES - 1);
    end else if (w_held && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Counter reaching zero only retires the reservation; an SC in that cycle still wins.
  assign w_timeout_expired = w_held & (timer_q == '0);
`else
  localparam logic c_timeout_legal = (TIMEOUT_CYCLES >= 2);

  assign w_timeout_expired = c_timeout_legal & 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rsv_addr_d    = rsv_addr_q;
    sc_rd_value_d = sc_rd_value_q;
    if (bus.i_flush) begin
      state_d = RSV_NONE;
    end else if (w_lr_accept) begin
      state_d    = RSV_HELD;
      rsv_addr_d = (bus.i_data_memory_address >> GRANULE_LOG2) << GRANULE_LOG2;
    end else if (w_sc_accept) begin
      // Any accepted SC consumes the reservation, successful or not.
      state_d       = RSV_NONE;
      sc_rd_value_d = w_sc_success ? '0 : XLEN'(1);
    end else if (w_store_hit || w_amo_hit || w_timeout_expired) begin
      state_d = RSV_NONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= RSV_NONE;
      rsv_addr_q    <= '0;
      sc_rd_value_q <= '0;
    end else begin
      state_q       <= state_d;
      rsv_addr_q    <= rsv_addr_d;
      sc_rd_value_q <= sc_rd_value_d;
    end
  end

  assign bus.o_sc_success        = w_sc_success;
  assign bus.o_sc_write_enable   = w_sc_success;
  assign bus.o_sc_rd_value       = sc_rd_value_q;
  assign bus.o_reservation_valid = w_held;
  assign bus.o_reservation_addr  = rsv_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_lr_sc_reservation_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lr_sc_reservation_unit: directed scoreboard bench for the LR/SC unit. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lr_sc_reservation_unit;
  localparam int XLEN = 32;
`ifdef LR_SC_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [XLEN-1:0] sb_q[$];

  lr_sc_reservation_unit_if #(.XLEN(XLEN)) bus ();

  lr_sc_reservation_unit #(.XLEN(XLEN), .GRANULE_LOG2(2), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_stall = 0; bus.i_flush = 0; bus.i_is_lr = 0; bus.i_is_sc = 0;
    bus.i_data_memory_address = '0;
    bus.i_store_write_enable = 0; bus.i_store_address = '0;
    bus.i_amo_write_enable = 0; bus.i_amo_write_addr = '0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lr(input logic [XLEN-1:0] a);
    bus.i_is_lr = 1; bus.i_data_memory_address = a;
    step();
    idle();
  endtask

  task automatic do_sc(input string tag, input logic [XLEN-1:0] a, input logic exp_ok);
    bus.i_is_sc = 1; bus.i_data_memory_address = a;
    #1;
    chk({tag, "_success"}, XLEN'(bus.o_sc_success), XLEN'(exp_ok));
    chk({tag, "_we"}, XLEN'(bus.o_sc_write_enable), XLEN'(exp_ok));
    sb_q.push_back(exp_ok ? XLEN'(0) : XLEN'(1));
    step();
    idle();
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, XLEN'(1), XLEN'(0));
    end else begin
      chk({tag, "_rd"}, bus.o_sc_rd_value, sb_q.pop_front());
    end
    chk({tag, "_valid_after"}, XLEN'(bus.o_reservation_valid), XLEN'(0));
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    chk("rst_valid", XLEN'(bus.o_reservation_valid), 0);
    chk("rst_addr", bus.o_reservation_addr, 0);
    chk("rst_rd", bus.o_sc_rd_value, 0);
    chk("rst_we", XLEN'(bus.o_sc_write_enable), 0);
    chk("rst_succ", XLEN'(bus.o_sc_success), 0);
    rst = 0;
    step();

    // LR then SC three cycles later
    do_lr(32'h100);
    chk("lr1_valid", XLEN'(bus.o_reservation_valid), 1);
    chk("lr1_addr", bus.o_reservation_addr, 32'h100);
    chk("hold_no_verdict", XLEN'(bus.o_sc_success), 0);
    step(); step();
    do_sc("sc1", 32'h100, 1);

    // Matching AMO write kills the reservation
    do_lr(32'h100);
    bus.i_amo_write_enable = 1; bus.i_amo_write_addr = 32'h102;
    step(); idle();
    chk("amo_kill_valid", XLEN'(bus.o_reservation_valid), 0);
    do_sc("sc_after_amo", 32'h100, 0);

    // Store to a different granule does not
    do_lr(32'h100);
    bus.i_store_write_enable = 1; bus.i_store_address = 32'h104;
    step(); idle();
    chk("store_other_valid", XLEN'(bus.o_reservation_valid), 1);
    do_sc("sc_store_other", 32'h100, 1);
    do_sc("sc_second", 32'h100, 0);

    // Matching regular store kills it
    do_lr(32'h100);
    bus.i_store_write_enable = 1; bus.i_store_address = 32'h103;
    step(); idle();
    chk("store_hit_valid", XLEN'(bus.o_reservation_valid), 0);

    // Address mismatch and alignment
    do_lr(32'h200);
    chk("lr200_addr", bus.o_reservation_addr, 32'h200);
    do_sc("sc_mismatch", 32'h100, 0);
    do_lr(32'h10B);
    chk("lr_align_addr", bus.o_reservation_addr, 32'h108);
    do_lr(32'h104);
    chk("relr_addr", bus.o_reservation_addr, 32'h104);

    // SC held off by a two-cycle stall
    bus.i_is_sc = 1; bus.i_data_memory_address = 32'h104; bus.i_stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_we", XLEN'(bus.o_sc_write_enable), 0);
      chk("stall_succ", XLEN'(bus.o_sc_success), 0);
      step();
      chk("stall_valid", XLEN'(bus.o_reservation_valid), 1);
      chk("stall_rd", bus.o_sc_rd_value, 1);
    end
    bus.i_stall = 0;
    do_sc("sc_after_stall", 32'h104, 1);

    // Flush clears; flush blocks a same-cycle LR
    do_lr(32'h300);
    bus.i_flush = 1;
    step(); idle();
    chk("flush_valid", XLEN'(bus.o_reservation_valid), 0);
    bus.i_flush = 1; bus.i_is_lr = 1; bus.i_data_memory_address = 32'h300;
    step(); idle();
    chk("flush_lr_valid", XLEN'(bus.o_reservation_valid), 0);

    // LR beats a same-cycle matching AMO write
    bus.i_is_lr = 1; bus.i_data_memory_address = 32'h400;
    bus.i_amo_write_enable = 1; bus.i_amo_write_addr = 32'h400;
    step(); idle();
    chk("lr_vs_amo_valid", XLEN'(bus.o_reservation_valid), 1);
    do_sc("sc_after_lr_amo", 32'h400, 1);

`ifdef LR_SC_TIMEOUT_EN
    do_lr(32'h500);
    repeat (3) step();
    do_sc("sc_in_time", 32'h500, 1);
    do_lr(32'h500);
    repeat (4) step();
    chk("timeout_valid", XLEN'(bus.o_reservation_valid), 0);
    step();
    do_sc("sc_timed_out", 32'h500, 0);
`else
    do_lr(32'h500);
    repeat (100) step();
    chk("long_hold_valid", XLEN'(bus.o_reservation_valid), 1);
    do_sc("sc_long_hold", 32'h500, 1);
`endif

    // Async reset mid-hold with a failed SC result latched
    do_sc("sc_pre_rst", 32'h600, 0);
    do_lr(32'h600);
    bus.i_is_sc = 1; bus.i_data_memory_address = 32'h600;
    #2;
    rst = 1;
    #1;
    chk("arst_valid", XLEN'(bus.o_reservation_valid), 0);
    chk("arst_addr", bus.o_reservation_addr, 0);
    chk("arst_rd", bus.o_sc_rd_value, 0);
    chk("arst_we", XLEN'(bus.o_sc_write_enable), 0);
    chk("arst_succ", XLEN'(bus.o_sc_success), 0);
    idle();
    step();
    rst = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
